// File: rtl/spi_master_byte_if.sv
// Host-side byte handshake plus SPI pin bundle for spi_master_byte.
// master modport is the initiator's view; slave modport is the host/pin side.
interface spi_master_byte_if;
    logic       start;
    logic [7:0] tx_byte;
    logic       busy;
    logic       done;
    logic [7:0] rx_byte;
    logic       SCK;
    logic       MOSI;
    logic       MISO;
    logic       SSEL;

    modport master (
        input  start, tx_byte, MISO,
        output busy, done, rx_byte, SCK, MOSI, SSEL
    );

    modport slave (
        output start, tx_byte, MISO,
        input  busy, done, rx_byte, SCK, MOSI, SSEL
    );
endinterface

// File: rtl/spi_master_byte.sv
// SPI mode-0 initiator, one 8-bit MSB-first full-duplex transfer per start.
// Define SPI_MASTER_HOLD_EN to add ssel_hold and a HOLD state for multi-byte frames.
module spi_master_byte #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SPI_MASTER_HOLD_EN
    input  logic ssel_hold,
`endif
    spi_master_byte_if.master bus
);

    localparam int CNT_MAX = (CLK_DIV > CS_SETUP) ?
                             ((CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE) :
                             ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] IDLE_LAST  = CW'(CS_IDLE - 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, GAP, HOLD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      tx_sh_q, tx_sh_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            sck_q, sck_d;
    logic            mosi_q, mosi_d;
    logic            ssel_q, ssel_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitcnt_d  = bitcnt_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_byte_d = rx_byte_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        ssel_d    = ssel_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tx_sh_d  = bus.tx_byte;
                    bitcnt_d = '0;
                    cnt_d    = '0;
                    ssel_d   = 1'b0;
                    busy_d   = 1'b1;
                    mosi_d   = bus.tx_byte[7];
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = XFER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            XFER: begin
                // bitcnt reaching 8 marks the cycle after the last falling edge
                if (bitcnt_q == 4'd8) begin
                    rx_byte_d = rx_sh_q;
                    done_d    = 1'b1;
                    mosi_d    = 1'b0;
                    cnt_d     = '0;
`ifdef SPI_MASTER_HOLD_EN
                    if (ssel_hold) begin
                        busy_d  = 1'b0;
                        state_d = HOLD;
                    end else begin
                        ssel_d  = 1'b1;
                        state_d = GAP;
                    end
`else
                    ssel_d  = 1'b1;
                    state_d = GAP;
`endif
                end else if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        rx_sh_d = {rx_sh_q[6:0], bus.MISO};
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q != 4'd7) begin
                            tx_sh_d = {tx_sh_q[6:0], 1'b0};
                            mosi_d  = tx_sh_q[6];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == IDLE_LAST) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef SPI_MASTER_HOLD_EN
            HOLD: begin
                if (!ssel_hold) begin
                    ssel_d  = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
                end else if (bus.start) begin
                    tx_sh_d  = bus.tx_byte;
                    bitcnt_d = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    mosi_d   = bus.tx_byte[7];
                    state_d  = XFER;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bitcnt_q  <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_byte_q <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            ssel_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitcnt_q  <= bitcnt_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_byte_q <= rx_byte_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            ssel_q    <= ssel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.SCK     = sck_q;
    assign bus.MOSI    = mosi_q;
    assign bus.SSEL    = ssel_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_byte = rx_byte_q;

endmodule

// File: tb/tb_spi_master_byte.sv
// Directed plus randomized bench for spi_master_byte against an SPI slave model.
module tb_spi_master_byte;
    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_IDLE  = 2;
    localparam int LOW_CYC  = CS_SETUP + 16 * CLK_DIV + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    spi_master_byte_if bus();
`ifdef SPI_MASTER_HOLD_EN
    logic ssel_hold = 1'b0;
`endif

    spi_master_byte #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_IDLE(CS_IDLE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef SPI_MASTER_HOLD_EN
        .ssel_hold(ssel_hold),
`endif
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;

    // 0: loopback, 1: tied high, 2: tied low, 3: slave model
    logic [1:0] miso_mode = 2'd0;
    logic [7:0] byte_send = 8'h00;
    logic [7:0] slave_tx_reg = 8'h00;
    logic [7:0] slave_sh = 8'h00;
    logic [7:0] slave_rcv = 8'h00;
    logic       ssel_prev = 1'b1;
    logic       sck_prev = 1'b0;
    int         rises = 0;
    int         done_cnt = 0;
    logic       mosi_bits[$];
    logic [7:0] slave_seen[$];
    time        fall_t[$];
    time        rise_t[$];

    assign bus.MISO = (miso_mode == 2'd0) ? bus.MOSI :
                      (miso_mode == 2'd1) ? 1'b1 :
                      (miso_mode == 2'd2) ? 1'b0 : slave_sh[7];

    // Slave model: loads its reply at SSEL fall, shifts on SCK fall, samples on SCK rise,
    // and picks up byte_send as the next reply when SSEL rises.
    always @(bus.SCK or bus.SSEL) begin
        if (bus.SSEL !== ssel_prev) begin
            if (bus.SSEL === 1'b0) begin
                slave_sh  = slave_tx_reg;
                slave_rcv = 8'h00;
                fall_t.push_back($time);
            end else if (bus.SSEL === 1'b1) begin
                slave_seen.push_back(slave_rcv);
                slave_tx_reg = byte_send;
                rise_t.push_back($time);
            end
        end
        if (bus.SCK !== sck_prev && bus.SSEL === 1'b0) begin
            if (bus.SCK === 1'b1) begin
                rises++;
                mosi_bits.push_back(bus.MOSI);
                slave_rcv = {slave_rcv[6:0], bus.MOSI};
            end else if (bus.SCK === 1'b0) begin
                slave_sh = {slave_sh[6:0], 1'b0};
            end
        end
        ssel_prev = bus.SSEL;
        sck_prev  = bus.SCK;
    end

    always @(posedge bus.done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy_low();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("busy_low_timeout", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic wait_done(output bit ok);
        int n = 0;
        while (bus.done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.done === 1'b1);
        chk("done_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic chk_mosi(input int mb, input logic [7:0] tx, input string tag);
        for (int i = 0; i < 8; i++) begin
            if (mb + i < mosi_bits.size())
                chk({tag, "_mosi_bit"}, {31'd0, mosi_bits[mb+i]}, {31'd0, tx[7-i]});
            else
                chk({tag, "_mosi_missing"}, 32'd0, 32'd1);
        end
    endtask

    task automatic do_xfer(input logic [7:0] tx, input logic [7:0] exp_rx, input string tag);
        int rb, mb, db;
        bit ok;
        wait_busy_low();
        @(negedge clk);
        rb = rises;
        mb = mosi_bits.size();
        db = done_cnt;
        bus.tx_byte = tx;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.tx_byte = ~tx;
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        chk({tag, "_ssel_low"}, {31'd0, bus.SSEL}, 32'd0);
        chk({tag, "_mosi_first"}, {31'd0, bus.MOSI}, {31'd0, tx[7]});
        wait_done(ok);
        if (ok) begin
            chk({tag, "_rx"}, {24'd0, bus.rx_byte}, {24'd0, exp_rx});
            chk({tag, "_rises"}, rises - rb, 32'd8);
            chk({tag, "_ssel_high_at_done"}, {31'd0, bus.SSEL}, 32'd1);
            chk({tag, "_ssel_low_cycles"}, int'((rise_t[$] - fall_t[$]) / 10), LOW_CYC);
            chk_mosi(mb, tx, tag);
            @(negedge clk);
            chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
            chk({tag, "_done_count"}, done_cnt - db, 32'd1);
        end
    endtask

    initial begin
        int rb, mb, db, si, n;
        bit ok;
        logic [7:0] prev_send, s, t;
        bus.start   = 1'b0;
        bus.tx_byte = 8'h00;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_sck", {31'd0, bus.SCK}, 32'd0);
        chk("rst_ssel", {31'd0, bus.SSEL}, 32'd1);
        chk("rst_mosi", {31'd0, bus.MOSI}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_rx", {24'd0, bus.rx_byte}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        miso_mode = 2'd0;
        do_xfer(8'hA5, 8'hA5, "loop_a5");

        miso_mode = 2'd1;
        do_xfer(8'h00, 8'hFF, "miso1");
        miso_mode = 2'd2;
        do_xfer(8'hFF, 8'h00, "miso0");

        // a second start during busy must be dropped
        miso_mode = 2'd0;
        wait_busy_low();
        @(negedge clk);
        rb = rises; mb = mosi_bits.size(); db = done_cnt;
        bus.tx_byte = 8'h3C; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.tx_byte = 8'hC3; bus.start = 1'b1;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        wait_done(ok);
        chk("busy_ign_rx", {24'd0, bus.rx_byte}, 32'h3C);
        repeat (200) @(negedge clk);
        chk("busy_ign_done_count", done_cnt - db, 32'd1);
        chk("busy_ign_rises", rises - rb, 32'd8);
        chk_mosi(mb, 8'h3C, "busy_ign");

        // reset mid-transfer after the third SCK rise
        wait_busy_low();
        @(negedge clk);
        rb = rises;
        bus.tx_byte = 8'hF0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (rises - rb < 3 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_third_rise", rises - rb, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sck", {31'd0, bus.SCK}, 32'd0);
        chk("midrst_ssel", {31'd0, bus.SSEL}, 32'd1);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_rx", {24'd0, bus.rx_byte}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_xfer(8'h5A, 8'h5A, "post_rst");

        // slave model: first reply is its reset content, second is byte_send
        miso_mode = 2'd3;
        byte_send = 8'h81;
        si = slave_seen.size();
        do_xfer(8'h12, 8'h00, "slv1");
        do_xfer(8'h34, 8'h81, "slv2");
        if (slave_seen.size() >= si + 2) begin
            chk("slv_seen1", {24'd0, slave_seen[si]}, 32'h12);
            chk("slv_seen2", {24'd0, slave_seen[si+1]}, 32'h34);
        end else begin
            chk("slv_seen_count", slave_seen.size() - si, 32'd2);
        end
        chk("slv_gap_ok", {31'd0, ((fall_t[$] - rise_t[$-1]) / 10) >= CS_IDLE}, 32'd1);

        prev_send = 8'h81;
        for (int k = 0; k < 6; k++) begin
            s = 8'($urandom_range(0, 255));
            t = 8'($urandom_range(0, 255));
            byte_send = s;
            si = slave_seen.size();
            do_xfer(t, prev_send, "rnd");
            if (si < slave_seen.size())
                chk("rnd_slave_seen", {24'd0, slave_seen[si]}, {24'd0, t});
            else
                chk("rnd_slave_missing", 32'd0, 32'd1);
            prev_send = s;
        end

`ifdef SPI_MASTER_HOLD_EN
        miso_mode = 2'd0;
        wait_busy_low();
        @(negedge clk);
        rb = rises; si = rise_t.size();
        ssel_hold = 1'b1;
        bus.tx_byte = 8'h11; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(ok);
        chk("hold_rx1", {24'd0, bus.rx_byte}, 32'h11);
        chk("hold_ssel_low", {31'd0, bus.SSEL}, 32'd0);
        chk("hold_busy_low", {31'd0, bus.busy}, 32'd0);
        bus.tx_byte = 8'h22; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(ok);
        chk("hold_rx2", {24'd0, bus.rx_byte}, 32'h22);
        chk("hold_rises", rises - rb, 32'd16);
        chk("hold_no_ssel_rise", rise_t.size() - si, 32'd0);
        repeat (5) @(negedge clk);
        chk("hold_still_low", {31'd0, bus.SSEL}, 32'd0);
        ssel_hold = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold_release", {31'd0, bus.SSEL}, 32'd1);
        wait_busy_low();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
